// File: rtl/midi_pkg.sv
// Shared constants, FSM encoding and arbitration helper for the MIDI note framer.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_OFF_VEL  = 8'h40;
  localparam int         NUM_BTN       = 4;

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} framer_state_t;

  // Lowest set bit wins, so button 0 has the highest priority.
  function automatic logic [1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    lowest_set = 2'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/midi_note_framer_if.sv
// Byte-wide valid/ready link from the framer to the MIDI UART serializer.
interface midi_note_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for one push button.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic toggle
);
    localparam int CW = $clog2(DEBOUNCE_CNT);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_toggle;
    logic [CW-1:0] r_cnt;

    if (DEBOUNCE_CNT < 2) begin : g_bad_cnt
        $error("btn_debounce: DEBOUNCE_CNT must be at least 2");
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_toggle <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= raw;
            r_sync2  <= r_sync1;
            r_toggle <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
                r_stable <= ~r_stable;
                r_toggle <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign toggle = r_toggle;
endmodule

// File: rtl/midi_note_framer.sv
// Debounced buttons -> pending flags -> 3-byte MIDI Note On/Off messages over valid/ready.
module midi_note_framer
    import midi_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 16,
    parameter int CHANNEL      = 0,
    parameter int NOTE_BASE    = 60,
    parameter int VELOCITY     = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BTN-1:0]     btn,
    midi_note_framer_if.master     tx,
    output logic [NUM_BTN-1:0]     held,
    output logic                   led_active,
    output logic                   led_busy
);
    if (NOTE_BASE > 124) begin : g_bad_note
        $error("midi_note_framer: NOTE_BASE must be <= 124");
    end
    if (CHANNEL > 15) begin : g_bad_chan
        $error("midi_note_framer: CHANNEL must be 0..15");
    end

    logic [NUM_BTN-1:0] w_held;
    logic [NUM_BTN-1:0] w_toggle;
    logic [NUM_BTN-1:0] w_pend_next;
    logic [1:0]         w_sel;
    logic               w_dispatch;
    logic               w_accept;
    logic [7:0]         w_status_byte;
    logic [7:0]         w_note_byte;
    logic [7:0]         w_vel_byte;

    logic [NUM_BTN-1:0] r_pend;
    framer_state_t      r_state;
    logic               r_on;
    logic [1:0]         r_idx;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn[g]),
            .stable (w_held[g]),
            .toggle (w_toggle[g])
        );
    end

    assign w_sel         = lowest_set(r_pend);
    assign w_dispatch    = (r_state == IDLE) && (|r_pend);
    assign w_accept      = r_tx_valid && tx.tx_ready;
    assign w_status_byte = (w_held[w_sel] ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | {4'h0, 4'(CHANNEL)};
    assign w_note_byte   = {1'b0, 7'(NOTE_BASE + int'(r_idx))};
    assign w_vel_byte    = r_on ? {1'b0, 7'(VELOCITY)} : NOTE_OFF_VEL;

    // A press+release pair cancels in the flag; a toggle landing on the dispatch cycle keeps the flag set.
    // NOTE: default assignment first so every path drives w_pend_next and no latch is inferred.
    always_comb begin
        w_pend_next = r_pend ^ w_toggle;
        if (w_dispatch) w_pend_next[w_sel] = w_toggle[w_sel];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= '0;
            r_state    <= IDLE;
            r_on       <= 1'b0;
            r_idx      <= 2'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            case (r_state)
                IDLE: begin
                    if (w_dispatch) begin
                        r_on       <= w_held[w_sel];
                        r_idx      <= w_sel;
                        r_tx_data  <= w_status_byte;
                        r_tx_valid <= 1'b1;
                        r_state    <= STATUS;
                    end else begin
                        r_tx_valid <= 1'b0;
                    end
                end
                STATUS: if (w_accept) begin
                    r_tx_data <= w_note_byte;
                    r_state   <= NOTE;
                end
                NOTE: if (w_accept) begin
                    r_tx_data <= w_vel_byte;
                    r_state   <= VEL;
                end
                VEL: if (w_accept) begin
                    r_tx_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign held        = w_held;
    assign led_active  = |w_held;
    assign led_busy    = (r_state != IDLE);
endmodule
